// File: rtl/vga_pkg.sv
// Shared frame-buffer types and constants for the VGA/CPU memory arbiter.
package vga_pkg;

  // Kind of access travelling down the in-flight tag pipeline.
  typedef enum logic [1:0] {
    SLOT_NONE   = 2'd0,
    SLOT_VGA    = 2'd1,
    SLOT_CPU_RD = 2'd2,
    SLOT_CPU_WR = 2'd3
  } slot_t;

  localparam logic [15:0] FB_BASE       = 16'h3000;
  localparam int unsigned FB_COLS_WORDS = 40;
  localparam int unsigned FB_ROWS       = 60;

  // True when a tag belongs to a CPU access of either direction.
  function automatic logic is_cpu_slot(input slot_t s);
    return (s == SLOT_CPU_RD) || (s == SLOT_CPU_WR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: VGA fetches always win, the CPU takes every free
// slot, and the worst CPU stall run is recorded for bring-up.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned STALL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vga_req,
  input  logic [ADDR_WIDTH-1:0]  vga_addr,
  output logic [DATA_WIDTH-1:0]  vga_data,
  output logic                   vga_valid,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic                   cpu_ack,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [STALL_WIDTH-1:0] stall_max
);

  slot_t                  s1_q, s1_d;
  slot_t                  s2_q, s2_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]  vga_data_q, vga_data_d;
  logic                   vga_valid_q, vga_valid_d;
  logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic [STALL_WIDTH-1:0] stall_max_q, stall_max_d;
  logic [STALL_WIDTH-1:0] stall_cnt;

  logic cpu_busy_c;
  logic cpu_elig_c;
  logic issue_cpu_c;
  logic stall_inc_c;

  // CPU eligibility: one CPU op in flight at a time, and never in its ack cycle.
  always_comb begin
    cpu_busy_c  = is_cpu_slot(s1_q) || is_cpu_slot(s2_q) || cpu_ack_q;
    cpu_elig_c  = cpu_req && !cpu_busy_c;
    issue_cpu_c = cpu_elig_c && !vga_req;
    stall_inc_c = cpu_elig_c && vga_req;
  end

  // Issue decision: load the memory port registers and the stage-1 tag.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    s1_d        = SLOT_NONE;
    if (vga_req) begin
      mem_addr_d  = vga_addr;
      mem_wdata_d = cpu_wdata;
      s1_d        = SLOT_VGA;
    end else if (issue_cpu_c) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_we_d    = cpu_we;
      s1_d        = cpu_we ? SLOT_CPU_WR : SLOT_CPU_RD;
    end
  end

  // Stage-2 completion: route the memory read data to its requester.
  always_comb begin
    s2_d        = s1_q;
    vga_data_d  = vga_data_q;
    vga_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    case (s2_q)
      SLOT_VGA: begin
        vga_data_d  = mem_rdata;
        vga_valid_d = 1'b1;
      end
      SLOT_CPU_RD: begin
        cpu_rdata_d = mem_rdata;
        cpu_ack_d   = 1'b1;
      end
      SLOT_CPU_WR: begin
        cpu_ack_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Longest stall run seen; inherits saturation from the stall counter.
  always_comb begin
    stall_max_d = (stall_cnt > stall_max_q) ? stall_cnt : stall_max_q;
  end

  // Consecutive cycles an eligible CPU request lost to VGA.
  sat_counter #(
    .WIDTH (STALL_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_c),
    .clr   (issue_cpu_c),
    .count (stall_cnt)
  );

  // Pipeline and output registers; reset flushes both tag stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= SLOT_NONE;
      s2_q        <= SLOT_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      stall_max_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign vga_data  = vga_data_q;
  assign vga_valid = vga_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign stall_max = stall_max_q;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates the single synchronous-read port of the frame-buffer memory between the VGA address generator (real-time reader) and the CPU (reader/writer). It sits between the VGA fetch logic, the CPU memory interface and memory port B. VGA fetches always win so the display never starves. The CPU is served in every free slot, including all of blanking and the alternate cycles of the half-rate VGA fetch pattern. It also reports the worst-case CPU stall for bring-up.

## Interface
- ADDR_WIDTH, 16, memory word-address width
- DATA_WIDTH, 16, memory word width
- STALL_WIDTH, 8, width of the saturating stall statistic
---
- clk  in  1  system clock (50 MHz); single clock domain
- reset  in  1  synchronous, active-high reset
- vga_req  in  1  one-cycle fetch strobe from the VGA address generator
- vga_addr  in  ADDR_WIDTH  fetch address, valid with vga_req
- vga_data  out  DATA_WIDTH  fetched word; holds its value until the next vga_valid
- vga_valid  out  1  one-cycle pulse: vga_data updated
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req is high
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse for reads and writes
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ack; holds until the next read ack
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_we  out  1  registered write enable
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr is presented
- stall_max  out  STALL_WIDTH  largest number of consecutive cycles a pending CPU request lost arbitration; saturates at all-ones

## Operation
- **Issue decision**, evaluated every cycle, in priority order:
  1. vga_req=1: issue VGA read.
  2. Else the CPU is eligible: issue a CPU read or write.
  3. Else issue nothing.
- **CPU eligibility:** cpu_req=1 AND no CPU op in stage 1 or stage 2 AND cpu_ack=0 this cycle. The request held during the ack cycle is therefore never issued twice.
- **Issue registers, updated at the issuing edge:**
  - mem_addr and mem_wdata are loaded.
  - mem_we = 1 only for a CPU write.
  - Idle cycle: mem_we = 0; mem_addr and mem_wdata hold.
- **Pipeline tags:** an in-flight tag pipeline (stage 1 then stage 2) carries the slot type.
  - Slot type is an enum: SLOT_NONE, SLOT_VGA, SLOT_CPU_RD, SLOT_CPU_WR.
  - Stage 2 completion:
    - SLOT_VGA: vga_data <= mem_rdata; vga_valid = 1.
    - SLOT_CPU_RD: cpu_rdata <= mem_rdata; cpu_ack = 1.
    - SLOT_CPU_WR: cpu_ack = 1; cpu_rdata unchanged.
- **Back-to-back vga_req:** both are served, in order, one per cycle.
- **Simultaneous vga_req and eligible cpu_req:** VGA is issued; the CPU retries next cycle.
- **Stall statistic:**
  - A stall counter increments on each cycle where cpu_req=1, the CPU is otherwise eligible, and VGA took the slot.
  - The counter clears on any CPU issue.
  - stall_max <= max(stall_max, counter).
  - Both saturate at 2^STALL_WIDTH-1.
- **Address handling:** no decoding of addresses; any address passes through, frame-buffer or not.

## Timing
- **Reset values:** all outputs are 0, specifically mem_addr, mem_we, mem_wdata, vga_data, vga_valid, cpu_ack, cpu_rdata and stall_max. Both tag stages = SLOT_NONE; stall counter = 0.
- **Latency:** request sampled at edge E0 → mem_* valid after E0 → memory captures at E1 → vga_valid/cpu_ack high in the cycle after E2. This is 2 clocks for both VGA and CPU, fixed.
- **CPU throughput:**
  - With no VGA traffic: one CPU op per 3 cycles (issue, wait, ack-lockout).
  - Under a VGA strobe every other cycle: one CPU op per 4 cycles worst case.
- **Reset mid-operation:**
  - Reset on any edge flushes both tag stages.
  - No vga_valid or cpu_ack is produced for ops issued before reset.
  - mem_we = 0 from the reset edge.
  - If a CPU write was already on mem_* at that reset edge, it commits to memory but is never acked.
- **cpu_req protocol:** dropping cpu_req before ack is a protocol violation; the op still completes and acks.

## Structure
- Shared package vga_pkg:
  - slot_t enum.
  - FB_BASE = 16'h3000.
  - FB_COLS_WORDS = 40.
  - FB_ROWS = 60.
- Sub-module: sat_counter (parameterized width, inc/clr, saturating), used for the stall counter.
- The arbiter decision, tag pipeline and return muxing stay in the top module.

## Test plan
- **Reset:** reset high for 3 cycles mid-traffic → all outputs 0; no vga_valid/cpu_ack for 2 cycles after release.
- **CPU alone:**
  - Write 16'hBEEF to 16'h3005 → mem_we=1 with mem_addr=16'h3005 one cycle after the request; cpu_ack 2 cycles after the request.
  - Then read 16'h3005 → cpu_rdata=16'hBEEF with cpu_ack; exactly one mem_we pulse overall.
- **Collision:** vga_req and cpu_req (read 16'h3010) asserted in the same cycle → VGA issued first, CPU issued next cycle; vga_valid at +2, cpu_ack at +3; stall_max=1.
- **Half-rate VGA strobe:** vga_req every other cycle, addresses 16'h3000..16'h3027, with continuous CPU writes → every vga_valid returns the correct word in order; CPU acks arrive every 4 cycles; stall_max ≤ 1.
- **Starvation saturation:** vga_req held high for 300 cycles with cpu_req pending → no CPU issue; stall_max=8'hFF; CPU acked 2 cycles after vga_req drops.
- **Ack-cycle hold:** cpu_req kept high through the ack cycle and one cycle after → two distinct ops; the second issues the cycle after ack, never in the ack cycle.
